// File: rtl/fc_argmax_if.sv
// Score stream into the argmax block and the per-frame decision coming back out.
// The slave modport is the argmax side; the master modport is the score producer / result consumer.
interface fc_argmax_if #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned IDX_W  = 4
);
  logic                     valid_in;
  logic signed [DATA_W-1:0] data_in;
  logic                     frame_clear;
  logic                     valid_out;
  logic [IDX_W-1:0]         class_out;
  logic signed [DATA_W-1:0] max_score;
  logic [15:0]              frame_cnt;

  modport master (
    output valid_in, data_in, frame_clear,
    input  valid_out, class_out, max_score, frame_cnt
  );

  modport slave (
    input  valid_in, data_in, frame_clear,
    output valid_out, class_out, max_score, frame_cnt
  );
endinterface

// File: rtl/fc_argmax.sv
// Streaming argmax over OUTPUT_NUM signed class scores per frame; emits class index, max score, frame count.
// Optional readable score buffer (rd_addr/rd_data) enabled by defining FC_ARGMAX_SCORE_BUF_EN.
module fc_argmax #(
  parameter int unsigned OUTPUT_NUM = 10,
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned IDX_W      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  fc_argmax_if.slave               bus
`ifdef FC_ARGMAX_SCORE_BUF_EN
  ,
  input  logic [IDX_W-1:0]         rd_addr,
  output logic signed [DATA_W-1:0] rd_data
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUTPUT_NUM - 1);

  typedef enum logic {S_IDLE, S_ACC} state_t;

  state_t                   state_q,   state_d;
  logic [IDX_W-1:0]         idx_q,     idx_d;
  logic signed [DATA_W-1:0] run_max_q, run_max_d;
  logic [IDX_W-1:0]         run_idx_q, run_idx_d;
  logic                     valid_q,   valid_d;
  logic [IDX_W-1:0]         class_q,   class_d;
  logic signed [DATA_W-1:0] max_q,     max_d;
  logic [15:0]              cnt_q,     cnt_d;

  logic                     accept_c;
  logic signed [DATA_W-1:0] cand_max_c;
  logic [IDX_W-1:0]         cand_idx_c;

  // A score counts only when no abort is pending in the same cycle.
  assign accept_c = bus.valid_in && !bus.frame_clear;

  // State register and all datapath flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      run_max_q <= '0;
      run_idx_q <= '0;
      valid_q   <= 1'b0;
      class_q   <= '0;
      max_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      run_max_q <= run_max_d;
      run_idx_q <= run_idx_d;
      valid_q   <= valid_d;
      class_q   <= class_d;
      max_q     <= max_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    run_max_d  = run_max_q;
    run_idx_d  = run_idx_q;
    valid_d    = 1'b0;
    class_d    = class_q;
    max_d      = max_q;
    cnt_d      = cnt_q;
    cand_max_c = run_max_q;
    cand_idx_c = run_idx_q;

    // First score of a frame always loads; later ones replace only when strictly larger.
    if (state_q == S_IDLE || bus.data_in > run_max_q) begin
      cand_max_c = bus.data_in;
      cand_idx_c = idx_q;
    end

    if (bus.frame_clear) begin
      state_d   = S_IDLE;
      idx_d     = '0;
      run_max_d = '0;
      run_idx_d = '0;
    end else if (bus.valid_in) begin
      run_max_d = cand_max_c;
      run_idx_d = cand_idx_c;
      if (idx_q == LAST_IDX) begin
        state_d = S_IDLE;
        idx_d   = '0;
        valid_d = 1'b1;
        class_d = cand_idx_c;
        max_d   = cand_max_c;
        cnt_d   = cnt_q + 16'd1;
      end else begin
        state_d = S_ACC;
        idx_d   = idx_q + IDX_W'(1);
      end
    end
  end

  assign bus.valid_out = valid_q;
  assign bus.class_out = class_q;
  assign bus.max_score = max_q;
  assign bus.frame_cnt = cnt_q;

`ifdef FC_ARGMAX_SCORE_BUF_EN
  logic signed [DATA_W-1:0] score_buf_q [OUTPUT_NUM];

  // Score buffer survives frame_clear; only reset wipes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(OUTPUT_NUM); i++) score_buf_q[i] <= '0;
      rd_data <= '0;
    end else begin
      if (accept_c) score_buf_q[idx_q] <= bus.data_in;
      rd_data <= (32'(rd_addr) < OUTPUT_NUM) ? score_buf_q[rd_addr] : '0;
    end
  end
`else
  logic unused_accept_c;
  assign unused_accept_c = accept_c;
`endif

endmodule
